// File: rtl/alk_pkg.sv
// Shared types and constants for the ALK A/Q double-register shifter slice.
// Holds the FSM state enum, the fill-select encoding and the shift direction constants.
package alk_pkg;

    localparam int ALK_WIDTH = 8;
    localparam int ALK_CNTW  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FILL_SIN  = 2'd0,
        FILL_ONE  = 2'd1,
        FILL_WRAP = 2'd2
    } fill_sel_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // A step op forces a 1 in only when the flag for its own direction is active.
    function automatic fill_sel_e step_fill_sel(input logic dir,
                                                input logic qsi1_l,
                                                input logic asi1_l);
        logic flag;
        flag = (dir == DIR_LEFT) ? ~qsi1_l : ~asi1_l;
        return flag ? FILL_ONE : FILL_SIN;
    endfunction

endpackage

// File: rtl/alkqshf_step.sv
// Combinational single-bit shifter of the {A,Q} register pair.
// out_bit is the bit that leaves the pair; fill enters at the opposite end.
module alkqshf_step
    import alk_pkg::*;
#(
    parameter int WIDTH = ALK_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             out_bit
);

    assign out_bit = (dir == DIR_LEFT) ? a[WIDTH-1] : q[0];

    assign {a_nxt, q_nxt} = (dir == DIR_LEFT) ? {a[WIDTH-2:0], q, fill}
                                              : {fill, a, q[WIDTH-1:1]};

endmodule

// File: rtl/alkqshf.sv
// Iterative A/Q double-register shifter: loads A from the ALU, then shifts {A,Q} one bit per cycle.
// Optional sticky tracking of right-shifted-out bits is enabled by defining ALK_QSHF_STICKY_EN.
module alkqshf
    import alk_pkg::*;
#(
    parameter int WIDTH = ALK_WIDTH,
    parameter int CNTW  = ALK_CNTW
) (
    input  logic             clk_h,
    input  logic             reset_l,
    input  logic             uop_valid_h,
    input  logic             op_shf_h,
    input  logic             op_rot_h,
    input  logic             op_qsi1_l,
    input  logic             op_asi1_l,
    input  logic             op_wbus30_h,
    input  logic             shf_dir_h,
    input  logic [CNTW-1:0]  shf_cnt_h,
    input  logic [WIDTH-1:0] alu_h,
    input  logic [WIDTH-1:0] wbus_h,
    input  logic             sin_h,
    output logic [WIDTH-1:0] a_h,
    output logic [WIDTH-1:0] q_h,
    output logic             sout_h,
    output logic             busy_h,
    output logic             done_h,
    output logic             sticky_h
);

    state_e          state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] q_d;
    logic [CNTW-1:0] cnt_q;
    logic            dir_q;
    fill_sel_e       fill_sel_q;

    logic any_op;
    logic accept;
    logic shifting;
    logic wrap_bit;
    logic fill_bit;
    logic step_out;

    assign shifting = (state_q == SHIFT);
    assign any_op   = op_shf_h | op_rot_h | op_wbus30_h | ~op_qsi1_l | ~op_asi1_l;
    assign accept   = uop_valid_h & ~shifting & any_op;

    // Wrap bit is derived here rather than from the step block to keep the fill path loop-free.
    assign wrap_bit = (dir_q == DIR_LEFT) ? a_q[WIDTH-1] : q_q[0];

    always_comb begin
        fill_bit = sin_h;
        unique case (fill_sel_q)
            FILL_ONE:  fill_bit = 1'b1;
            FILL_WRAP: fill_bit = wrap_bit;
            default:   fill_bit = sin_h;
        endcase
    end

    alkqshf_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .a      (a_q),
        .q      (q_q),
        .dir    (dir_q),
        .fill   (fill_bit),
        .a_nxt  (a_d),
        .q_nxt  (q_d),
        .out_bit(step_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            a_q        <= '0;
            q_q        <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_RIGHT;
            fill_sel_q <= FILL_SIN;
        end else begin
            unique case (state_q)
                SHIFT: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CNTW'(1);
                    if (cnt_q <= CNTW'(1)) begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    if (!accept) begin
                        state_q <= IDLE;
                    end else if (op_wbus30_h) begin
                        q_q     <= wbus_h;
                        state_q <= DONE;
                    end else if (op_rot_h || op_shf_h) begin
                        a_q        <= alu_h;
                        cnt_q      <= shf_cnt_h;
                        dir_q      <= shf_dir_h;
                        fill_sel_q <= op_rot_h ? FILL_WRAP : FILL_SIN;
                        state_q    <= (shf_cnt_h != '0) ? SHIFT : DONE;
                    end else begin
                        a_q        <= alu_h;
                        cnt_q      <= CNTW'(1);
                        dir_q      <= shf_dir_h;
                        fill_sel_q <= step_fill_sel(shf_dir_h, op_qsi1_l, op_asi1_l);
                        state_q    <= SHIFT;
                    end
                end
            endcase
        end
    end

`ifdef ALK_QSHF_STICKY_EN
    logic sticky_q;

    // Cleared by any shifting accept; a Q-only load leaves the previous result visible.
    always_ff @(posedge clk_h) begin
        if (!reset_l) begin
            sticky_q <= 1'b0;
        end else if (accept && !op_wbus30_h) begin
            sticky_q <= 1'b0;
        end else if (shifting && (dir_q == DIR_RIGHT) && (fill_sel_q != FILL_WRAP)) begin
            sticky_q <= sticky_q | q_q[0];
        end
    end

    assign sticky_h = sticky_q;
`else
    assign sticky_h = 1'b0;
`endif

    assign a_h    = a_q;
    assign q_h    = q_q;
    assign busy_h = shifting;
    assign done_h = (state_q == DONE);
    assign sout_h = shifting ? step_out : 1'b0;

endmodule

// File: tb/tb_alkqshf.sv
// Self-checking bench for alkqshf: directed cases with literal results, then randomized traffic
// compared every cycle against a behavioural {A,Q} model.
module tb_alkqshf;

    localparam int W  = 8;
    localparam int CW = 5;

    logic          clk_h = 1'b0;
    logic          reset_l;
    logic          uop_valid_h;
    logic          op_shf_h;
    logic          op_rot_h;
    logic          op_qsi1_l;
    logic          op_asi1_l;
    logic          op_wbus30_h;
    logic          shf_dir_h;
    logic [CW-1:0] shf_cnt_h;
    logic [W-1:0]  alu_h;
    logic [W-1:0]  wbus_h;
    logic          sin_h;
    logic [W-1:0]  a_h;
    logic [W-1:0]  q_h;
    logic          sout_h;
    logic          busy_h;
    logic          done_h;
    logic          sticky_h;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    // Behavioural model: the pair as one 2W-bit vector plus the number of steps still owed.
    logic [2*W-1:0] m_aq     = '0;
    int             m_left   = 0;
    logic           m_dir    = 1'b0;
    logic           m_rot    = 1'b0;
    logic           m_one    = 1'b0;
    logic           m_sticky = 1'b0;
    logic           m_done   = 1'b0;

    always #5 clk_h = ~clk_h;

    alkqshf #(
        .WIDTH(W),
        .CNTW (CW)
    ) dut (
        .clk_h      (clk_h),
        .reset_l    (reset_l),
        .uop_valid_h(uop_valid_h),
        .op_shf_h   (op_shf_h),
        .op_rot_h   (op_rot_h),
        .op_qsi1_l  (op_qsi1_l),
        .op_asi1_l  (op_asi1_l),
        .op_wbus30_h(op_wbus30_h),
        .shf_dir_h  (shf_dir_h),
        .shf_cnt_h  (shf_cnt_h),
        .alu_h      (alu_h),
        .wbus_h     (wbus_h),
        .sin_h      (sin_h),
        .a_h        (a_h),
        .q_h        (q_h),
        .sout_h     (sout_h),
        .busy_h     (busy_h),
        .done_h     (done_h),
        .sticky_h   (sticky_h)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic ob;
        logic fill;
        if (!reset_l) begin
            m_aq     = '0;
            m_left   = 0;
            m_sticky = 1'b0;
            m_done   = 1'b0;
        end else if (m_left > 0) begin
            ob   = m_dir ? m_aq[2*W-1] : m_aq[0];
            fill = m_rot ? ob : (m_one ? 1'b1 : sin_h);
            if (!m_dir && !m_rot) m_sticky = m_sticky | m_aq[0];
            m_aq   = m_dir ? {m_aq[2*W-2:0], fill} : {fill, m_aq[2*W-1:1]};
            m_left = m_left - 1;
            m_done = (m_left == 0);
        end else begin
            m_done = 1'b0;
            if (uop_valid_h) begin
                if (op_wbus30_h) begin
                    m_aq[W-1:0] = wbus_h;
                    m_done      = 1'b1;
                end else if (op_rot_h || op_shf_h) begin
                    m_aq[2*W-1:W] = alu_h;
                    m_left        = int'(shf_cnt_h);
                    m_dir         = shf_dir_h;
                    m_rot         = op_rot_h;
                    m_one         = 1'b0;
                    m_sticky      = 1'b0;
                    m_done        = (m_left == 0);
                end else if (!op_qsi1_l || !op_asi1_l) begin
                    m_aq[2*W-1:W] = alu_h;
                    m_left        = 1;
                    m_dir         = shf_dir_h;
                    m_rot         = 1'b0;
                    m_one         = shf_dir_h ? !op_qsi1_l : !op_asi1_l;
                    m_sticky      = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic exp_sout;
        logic exp_sticky;
        exp_sout = (m_left > 0) ? (m_dir ? m_aq[2*W-1] : m_aq[0]) : 1'b0;
`ifdef ALK_QSHF_STICKY_EN
        exp_sticky = m_sticky;
`else
        exp_sticky = 1'b0;
`endif
        check("a_h",      32'(a_h),      32'(m_aq[2*W-1:W]));
        check("q_h",      32'(q_h),      32'(m_aq[W-1:0]));
        check("busy_h",   32'(busy_h),   32'(m_left > 0));
        check("done_h",   32'(done_h),   32'(m_done));
        check("sout_h",   32'(sout_h),   32'(exp_sout));
        check("sticky_h", 32'(sticky_h), 32'(exp_sticky));
    endtask

    initial forever begin
        @(posedge clk_h);
        model_edge();
    end

    initial forever begin
        @(negedge clk_h);
        if (check_en) compare_all();
    end

    task automatic clear_ops();
        uop_valid_h = 1'b0;
        op_shf_h    = 1'b0;
        op_rot_h    = 1'b0;
        op_qsi1_l   = 1'b1;
        op_asi1_l   = 1'b1;
        op_wbus30_h = 1'b0;
    endtask

    // Drives one uop now, holds it across the next rising edge, then withdraws it.
    task automatic issue(input logic wbus30, input logic rot, input logic shf,
                         input logic qsi1_l, input logic asi1_l, input logic dir,
                         input logic [CW-1:0] cnt, input logic [W-1:0] alu,
                         input logic [W-1:0] wbus);
        op_wbus30_h = wbus30;
        op_rot_h    = rot;
        op_shf_h    = shf;
        op_qsi1_l   = qsi1_l;
        op_asi1_l   = asi1_l;
        shf_dir_h   = dir;
        shf_cnt_h   = cnt;
        alu_h       = alu;
        wbus_h      = wbus;
        uop_valid_h = 1'b1;
        @(posedge clk_h);
        #1;
        clear_ops();
    endtask

    // Returns the cycle index (1 = first cycle after the current edge) at which done_h is seen.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk_h);
            if (done_h === 1'b1) begin
                lat = k;
                break;
            end
            @(posedge clk_h);
        end
    endtask

    int   lat;
    logic exp_sticky_step;

    initial begin
        reset_l   = 1'b0;
        sin_h     = 1'b0;
        shf_dir_h = 1'b0;
        shf_cnt_h = '0;
        alu_h     = '0;
        wbus_h    = '0;
        clear_ops();
        repeat (2) @(posedge clk_h);
        #1;
        check_en = 1'b1;

        @(negedge clk_h);
        check("rst_a", 32'(a_h), 32'h0);
        check("rst_q", 32'(q_h), 32'h0);
        check("rst_busy_done", 32'({busy_h, done_h, sticky_h, sout_h}), 32'h0);
        reset_l = 1'b1;

        // Reset in the middle of a shift with three steps still to go.
        @(negedge clk_h);
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 8'hFF, 8'h00);
        repeat (2) begin
            @(posedge clk_h);
            #1;
        end
        reset_l = 1'b0;
        @(posedge clk_h);
        #1;
        reset_l = 1'b1;
        @(negedge clk_h);
        check("midrst_a", 32'(a_h), 32'h0);
        check("midrst_q", 32'(q_h), 32'h0);
        check("midrst_flags", 32'({busy_h, done_h, sticky_h}), 32'h0);

        // Q load, then a left shift of 3 issued in the load's DONE cycle.
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 8'h40);
        wait_done(4, lat);
        check("wbus_lat", 32'(lat), 32'd1);
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 8'h81, 8'h00);
        wait_done(10, lat);
        check("shl3_lat", 32'(lat), 32'd4);
        check("shl3_a", 32'(a_h), 32'h0A);
        check("shl3_q", 32'(q_h), 32'h00);
        check("shl3_sticky", 32'(sticky_h), 32'h0);

        // Rotate right by 4 with Q = 0x34.
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 8'h34);
        wait_done(4, lat);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 8'h12, 8'h00);
        wait_done(10, lat);
        check("rotr4_lat", 32'(lat), 32'd5);
        check("rotr4_a", 32'(a_h), 32'h41);
        check("rotr4_q", 32'(q_h), 32'h23);
        check("rotr4_sticky", 32'(sticky_h), 32'h0);

        // Single right step with A shift-in forced to 1.
        issue(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00, 8'h03);
        wait_done(4, lat);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
        wait_done(10, lat);
`ifdef ALK_QSHF_STICKY_EN
        exp_sticky_step = 1'b1;
`else
        exp_sticky_step = 1'b0;
`endif
        check("step_lat", 32'(lat), 32'd2);
        check("step_a", 32'(a_h), 32'h80);
        check("step_q", 32'(q_h), 32'h01);
        check("step_sticky", 32'(sticky_h), 32'(exp_sticky_step));

        // Zero-count shift: A loads, done next cycle, never busy.
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 8'h5A, 8'h00);
        wait_done(4, lat);
        check("cnt0_lat", 32'(lat), 32'd1);
        check("cnt0_a", 32'(a_h), 32'h5A);
        check("cnt0_q", 32'(q_h), 32'h01);
        check("cnt0_busy", 32'(busy_h), 32'h0);

        // A Q load presented while busy must be ignored.
        issue(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 8'h00, 8'h00);
        op_wbus30_h = 1'b1;
        wbus_h      = 8'hFF;
        uop_valid_h = 1'b1;
        @(posedge clk_h);
        #1;
        clear_ops();
        wait_done(10, lat);
        check("busyign_lat", 32'(lat + 1), 32'd3);
        check("busyign_a", 32'(a_h), 32'h00);
        check("busyign_q", 32'(q_h), 32'h04);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_h);
            #1;
            clear_ops();
            reset_l     = ($urandom_range(0, 99) != 0);
            uop_valid_h = ($urandom_range(0, 2) == 0);
            sin_h       = 1'($urandom_range(0, 1));
            shf_dir_h   = 1'($urandom_range(0, 1));
            shf_cnt_h   = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 31))
                                                     : CW'($urandom_range(0, 7));
            alu_h       = W'($urandom);
            wbus_h      = W'($urandom);
            case ($urandom_range(0, 5))
                0:       op_wbus30_h = 1'b1;
                1:       op_rot_h    = 1'b1;
                2:       op_shf_h    = 1'b1;
                3:       op_qsi1_l   = 1'b0;
                4:       op_asi1_l   = 1'b0;
                default: ;
            endcase
            if ($urandom_range(0, 7) == 0) op_rot_h  = 1'b1;
            if ($urandom_range(0, 7) == 0) op_shf_h  = 1'b1;
            if ($urandom_range(0, 7) == 0) op_qsi1_l = 1'b0;
            if ($urandom_range(0, 7) == 0) op_asi1_l = 1'b0;
        end

        @(posedge clk_h);
        #1;
        clear_ops();
        reset_l = 1'b1;
        repeat (40) @(posedge clk_h);
        @(negedge clk_h);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
